// File: rtl/rand_theta_gen.sv
// Pseudo-random angle source (0..359 deg) for the CORDIC modulator.
// Issues one angle per handshake, paces samples and flags lost responses.
module rand_theta_gen #(
    parameter logic [31:0] SEED     = 32'hACE1_2468,
    parameter int unsigned INTERVAL = 8,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        seed_load,
    input  logic [31:0] seed,
    input  logic        err_clr,
    input  logic        vld_i,
    output logic [31:0] theta,
    output logic        rand_shake,
    output logic [15:0] cnt,
    output logic        err
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GW = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;
    localparam logic [8:0]  ANGLE_LIMIT = 9'd360;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    state_t        state, state_d;
    logic [31:0]   lfsr, lfsr_d;
    logic [31:0]   theta_d;
    logic [1:0]    retry, retry_d;
    logic [15:0]   cnt_d;
    logic          err_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic [GW-1:0] gcnt, gcnt_d;
    logic [31:0]   lfsr_step;
    logic [8:0]    cand;
    logic          set_err;

    assign lfsr_step  = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    assign cand       = lfsr_step[8:0];
    assign rand_shake = (state == S_ISSUE);

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            lfsr  <= SEED;
            theta <= '0;
            retry <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            tcnt  <= '0;
            gcnt  <= '0;
        end else begin
            state <= state_d;
            lfsr  <= lfsr_d;
            theta <= theta_d;
            retry <= retry_d;
            cnt   <= cnt_d;
            err   <= err_d;
            tcnt  <= tcnt_d;
            gcnt  <= gcnt_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state;
        lfsr_d  = lfsr;
        theta_d = theta;
        retry_d = retry;
        cnt_d   = cnt;
        tcnt_d  = tcnt;
        gcnt_d  = gcnt;
        set_err = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (seed_load) begin
                    lfsr_d = (seed == 32'd0) ? SEED : seed;
                end
                if (en) begin
                    state_d = S_GEN;
                end
            end
            S_GEN: begin
                lfsr_d = lfsr_step;
                if (cand < ANGLE_LIMIT) begin
                    theta_d = {7'b0, cand, 16'h0000};
                    retry_d = '0;
                    state_d = S_ISSUE;
                end else if (retry != 2'd3) begin
                    retry_d = retry + 2'd1;
                end else begin
                    // Fourth rejection folds the candidate into 0..151
                    theta_d = {7'b0, 9'(cand - ANGLE_LIMIT), 16'h0000};
                    retry_d = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = cnt + 16'd1;
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (vld_i) begin
                    gcnt_d  = GW'(INTERVAL - 1);
                    state_d = S_GAP;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    set_err = 1'b1;
                    gcnt_d  = GW'(INTERVAL - 1);
                    state_d = S_GAP;
                end else begin
                    tcnt_d = tcnt + TW'(1);
                end
            end
            S_GAP: begin
                if (gcnt == '0) begin
                    state_d = en ? S_GEN : S_IDLE;
                end else begin
                    gcnt_d = gcnt - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (set_err) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err;
        end
    end

endmodule
